devices_regs_bank: RTL and testbench

//  Parametrised CPU-visible register bank for peripheral devices; successor to the fixed 4x8 register block.

---
 rtl/devices_regs_pkg.sv | 37 +++
 rtl/devices_regs_bank_if.sv | 33 +++
 rtl/devices_regs_irq.sv | 40 ++++
 rtl/devices_regs_bank.sv | 132 +++++++++++++
 tb/tb_devices_regs_bank.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/devices_regs_pkg.sv
// rtl/devices_regs_pkg.sv - shared decode types, address offsets and defaults for the device register bank
package devices_regs_pkg;

    localparam int unsigned DEFAULT_ID_VAL = 32'h0000_00A5;
    localparam int unsigned FIXED_REGS     = 4;

    typedef enum logic [2:0] {
        SEL_GEN,
        SEL_STATUS,
        SEL_PEND,
        SEL_MASK,
        SEL_ID,
        SEL_NONE
    } reg_sel_e;

    // Fixed-function registers sit directly above the general block.
    function automatic int unsigned status_ofs(input int unsigned num_regs);
        return num_regs;
    endfunction

    function automatic int unsigned pend_ofs(input int unsigned num_regs);
        return num_regs + 1;
    endfunction

    function automatic int unsigned mask_ofs(input int unsigned num_regs);
        return num_regs + 2;
    endfunction

    function automatic int unsigned id_ofs(input int unsigned num_regs);
        return num_regs + 3;
    endfunction

    function automatic int unsigned map_span(input int unsigned num_regs);
        return num_regs + FIXED_REGS;
    endfunction

endpackage

// File: rtl/devices_regs_bank_if.sv
// rtl/devices_regs_bank_if.sv - CPU-side register access bus between the slave decoder and the bank
interface devices_regs_bank_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic [ADDR_W-1:0] address;
    logic              write_en;
    logic [DATA_W-1:0] data_in;
    logic              read_en;
    logic [DATA_W-1:0] read_data;
    logic              read_valid;
    logic              addr_err;

    modport master (
        output address,
        output write_en,
        output data_in,
        output read_en,
        input  read_data,
        input  read_valid,
        input  addr_err
    );

    modport slave (
        input  address,
        input  write_en,
        input  data_in,
        input  read_en,
        output read_data,
        output read_valid,
        output addr_err
    );
endinterface

// File: rtl/devices_regs_irq.sv
// rtl/devices_regs_irq.sv - interrupt pending (W1C) and mask registers with the irq reduction
module devices_regs_irq #(
    parameter int                DATA_W     = 8,
    parameter logic [DATA_W-1:0] RESET_WORD = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pend_we,
    input  logic              mask_we,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] irq_set,
    output logic [DATA_W-1:0] pend,
    output logic [DATA_W-1:0] mask,
    output logic              irq
);

    logic [DATA_W-1:0] pend_q;
    logic [DATA_W-1:0] mask_q;
    logic [DATA_W-1:0] clr_bits;

    assign clr_bits = pend_we ? wdata : '0;

    // A new event in the same cycle as its clear must not be lost, so set is OR'd last.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_q <= '0;
            mask_q <= RESET_WORD;
        end else begin
            pend_q <= (pend_q & ~clr_bits) | irq_set;
            if (mask_we) begin
                mask_q <= wdata;
            end
        end
    end

    assign pend = pend_q;
    assign mask = mask_q;
    assign irq  = |(pend_q & mask_q);

endmodule

// File: rtl/devices_regs_bank.sv
// rtl/devices_regs_bank.sv - parametrised general RW registers plus STATUS/IRQ_PEND/IRQ_MASK/ID with registered reads
module devices_regs_bank
    import devices_regs_pkg::*;
#(
    parameter int          DATA_W    = 8,
    parameter int          NUM_REGS  = 4,
    parameter int          ADDR_W    = 4,
    parameter int unsigned RESET_VAL = 0,
    parameter int unsigned ID_VAL    = DEFAULT_ID_VAL
) (
    input  logic                       clk,
    input  logic                       reset,
    devices_regs_bank_if.slave         bus,
    output logic [NUM_REGS*DATA_W-1:0] reg_out,
    input  logic [DATA_W-1:0]          status_in,
    input  logic [DATA_W-1:0]          irq_set,
    output logic                       irq
);

    localparam logic [DATA_W-1:0] RESET_WORD = DATA_W'(RESET_VAL);
    localparam logic [DATA_W-1:0] ID_WORD    = DATA_W'(ID_VAL);
    localparam logic [ADDR_W-1:0] GEN_END    = ADDR_W'(NUM_REGS);
    localparam logic [ADDR_W-1:0] STATUS_A   = ADDR_W'(status_ofs(NUM_REGS));
    localparam logic [ADDR_W-1:0] PEND_A     = ADDR_W'(pend_ofs(NUM_REGS));
    localparam logic [ADDR_W-1:0] MASK_A     = ADDR_W'(mask_ofs(NUM_REGS));
    localparam logic [ADDR_W-1:0] ID_A       = ADDR_W'(id_ofs(NUM_REGS));

    if (NUM_REGS < 1 || map_span(NUM_REGS) > (64'd1 << ADDR_W)) begin : g_bad_cfg
        $error("devices_regs_bank: NUM_REGS+4 must fit in 2**ADDR_W and NUM_REGS >= 1");
    end

    reg_sel_e          sel;
    logic [DATA_W-1:0] gen_q [NUM_REGS];
    logic [DATA_W-1:0] pend;
    logic [DATA_W-1:0] mask;
    logic [DATA_W-1:0] rd_mux;
    logic [DATA_W-1:0] rdata_q;
    logic              rvalid_q;
    logic              aerr_q;
    logic              pend_we;
    logic              mask_we;

    // Full-width compares: upper address bits never alias onto a mapped register.
    always_comb begin
        sel = SEL_NONE;
        if (bus.address < GEN_END) begin
            sel = SEL_GEN;
        end else if (bus.address == STATUS_A) begin
            sel = SEL_STATUS;
        end else if (bus.address == PEND_A) begin
            sel = SEL_PEND;
        end else if (bus.address == MASK_A) begin
            sel = SEL_MASK;
        end else if (bus.address == ID_A) begin
            sel = SEL_ID;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                gen_q[i] <= RESET_WORD;
            end
        end else if (bus.write_en && sel == SEL_GEN) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (bus.address == ADDR_W'(i)) begin
                    gen_q[i] <= bus.data_in;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_out
        assign reg_out[g*DATA_W +: DATA_W] = gen_q[g];
    end

    assign pend_we = bus.write_en && sel == SEL_PEND;
    assign mask_we = bus.write_en && sel == SEL_MASK;

    devices_regs_irq #(
        .DATA_W     (DATA_W),
        .RESET_WORD (RESET_WORD)
    ) u_irq (
        .clk     (clk),
        .reset   (reset),
        .pend_we (pend_we),
        .mask_we (mask_we),
        .wdata   (bus.data_in),
        .irq_set (irq_set),
        .pend    (pend),
        .mask    (mask),
        .irq     (irq)
    );

    // Mux sees register state before this edge's write, giving read-before-write on collisions.
    always_comb begin
        rd_mux = '0;
        case (sel)
            SEL_GEN: begin
                for (int i = 0; i < NUM_REGS; i++) begin
                    if (bus.address == ADDR_W'(i)) begin
                        rd_mux = gen_q[i];
                    end
                end
            end
            SEL_STATUS: rd_mux = status_in;
            SEL_PEND:   rd_mux = pend;
            SEL_MASK:   rd_mux = mask;
            SEL_ID:     rd_mux = ID_WORD;
            default:    rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            aerr_q   <= 1'b0;
        end else begin
            rvalid_q <= bus.read_en;
            aerr_q   <= (bus.read_en || bus.write_en) && sel == SEL_NONE;
            if (bus.read_en) begin
                rdata_q <= rd_mux;
            end
        end
    end

    assign bus.read_data  = rdata_q;
    assign bus.read_valid = rvalid_q;
    assign bus.addr_err   = aerr_q;

endmodule

// File: tb/tb_devices_regs_bank.sv
// tb/tb_devices_regs_bank.sv - directed and randomized checks of devices_regs_bank against a behavioural model
module tb_devices_regs_bank;

    logic        clk;
    logic        reset;
    logic [31:0] reg_out;
    logic [7:0]  status_in;
    logic [7:0]  irq_set;
    logic        irq;

    int total;
    int bad;

    devices_regs_bank_if #(.ADDR_W(4), .DATA_W(8)) bus ();

    devices_regs_bank #(
        .DATA_W    (8),
        .NUM_REGS  (4),
        .ADDR_W    (4),
        .RESET_VAL (0),
        .ID_VAL    (32'hA5)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .reg_out   (reg_out),
        .status_in (status_in),
        .irq_set   (irq_set),
        .irq       (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: register file as a plain array indexed by address number.
    logic [7:0] m_gen [4];
    logic [7:0] m_pend;
    logic [7:0] m_mask;
    logic [7:0] m_rdata;
    logic       m_rvalid;
    logic       m_aerr;

    function automatic logic [7:0] m_read(input int a);
        if (a < 4)  return m_gen[a];
        if (a == 4) return status_in;
        if (a == 5) return m_pend;
        if (a == 6) return m_mask;
        if (a == 7) return 8'hA5;
        return 8'h00;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) m_gen[i] <= 8'h00;
            m_pend   <= 8'h00;
            m_mask   <= 8'h00;
            m_rdata  <= 8'h00;
            m_rvalid <= 1'b0;
            m_aerr   <= 1'b0;
        end else begin
            m_rvalid <= bus.read_en;
            m_aerr   <= (bus.read_en || bus.write_en) && int'(bus.address) > 7;
            if (bus.read_en) m_rdata <= m_read(int'(bus.address));
            m_pend <= (m_pend & ~((bus.write_en && bus.address == 4'd5) ? bus.data_in : 8'h00)) | irq_set;
            if (bus.write_en && int'(bus.address) < 4) m_gen[int'(bus.address)] <= bus.data_in;
            if (bus.write_en && bus.address == 4'd6) m_mask <= bus.data_in;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("model_read_valid", 32'(bus.read_valid), 32'(m_rvalid));
        check("model_read_data", 32'(bus.read_data), 32'(m_rdata));
        check("model_addr_err", 32'(bus.addr_err), 32'(m_aerr));
        check("model_irq", 32'(irq), 32'(|(m_pend & m_mask)));
        check("model_reg_out", reg_out, {m_gen[3], m_gen[2], m_gen[1], m_gen[0]});
    end

    // One access cycle; returns at edge+1 so the edge's results can be checked directly.
    task automatic access(input bit we, input bit re, input int a, input logic [7:0] d,
                          input logic [7:0] set);
        bus.write_en = we;
        bus.read_en  = re;
        bus.address  = 4'(a);
        bus.data_in  = d;
        irq_set      = set;
        @(posedge clk);
        #1;
        bus.write_en = 1'b0;
        bus.read_en  = 1'b0;
        irq_set      = 8'h00;
    endtask

    initial begin
        total        = 0;
        bad          = 0;
        reset        = 1'b1;
        bus.write_en = 1'b0;
        bus.read_en  = 1'b0;
        bus.address  = '0;
        bus.data_in  = '0;
        status_in    = 8'h00;
        irq_set      = 8'h00;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Reset in the middle of a write cycle aborts it.
        bus.write_en = 1'b1;
        bus.address  = 4'd2;
        bus.data_in  = 8'h77;
        #2 reset = 1'b1;
        #1;
        check("rst_read_data", 32'(bus.read_data), 32'h0);
        check("rst_read_valid", 32'(bus.read_valid), 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        check("rst_reg_out", reg_out, 32'h0);
        @(posedge clk);
        #1;
        bus.write_en = 1'b0;
        reset        = 1'b0;
        access(0, 1, 2, 8'h00, 8'h00);
        check("rst_gen2_read", 32'(bus.read_data), 32'h0);

        access(1, 0, 2, 8'h3C, 8'h00);
        access(0, 1, 2, 8'h00, 8'h00);
        check("gen2_read", 32'(bus.read_data), 32'h3C);
        check("gen2_valid", 32'(bus.read_valid), 32'h1);
        access(0, 0, 0, 8'h00, 8'h00);
        check("valid_one_cycle", 32'(bus.read_valid), 32'h0);
        check("data_holds", 32'(bus.read_data), 32'h3C);

        // Read and write to the same address in one cycle.
        access(1, 0, 1, 8'h11, 8'h00);
        access(1, 1, 1, 8'h22, 8'h00);
        check("rw_same_old", 32'(bus.read_data), 32'h11);
        access(0, 1, 1, 8'h00, 8'h00);
        check("rw_same_new", 32'(bus.read_data), 32'h22);

        access(1, 0, 6, 8'h04, 8'h00);
        access(0, 0, 0, 8'h00, 8'h05);
        check("irq_set", 32'(irq), 32'h1);
        access(0, 1, 5, 8'h00, 8'h00);
        check("pend_05", 32'(bus.read_data), 32'h05);
        access(1, 0, 5, 8'h04, 8'h00);
        check("irq_cleared", 32'(irq), 32'h0);
        access(0, 1, 5, 8'h00, 8'h00);
        check("pend_01", 32'(bus.read_data), 32'h01);
        access(1, 0, 5, 8'h01, 8'h01);
        access(0, 1, 5, 8'h00, 8'h00);
        check("set_beats_clear", 32'(bus.read_data), 32'h01);

        access(0, 1, 7, 8'h00, 8'h00);
        check("id_read", 32'(bus.read_data), 32'hA5);
        access(1, 0, 4, 8'hFF, 8'h00);
        check("status_wr_no_err", 32'(bus.addr_err), 32'h0);
        status_in = 8'h5A;
        access(0, 1, 4, 8'h00, 8'h00);
        check("status_read", 32'(bus.read_data), 32'h5A);

        access(0, 1, 9, 8'h00, 8'h00);
        check("unmapped_rd_err", 32'(bus.addr_err), 32'h1);
        check("unmapped_rd_data", 32'(bus.read_data), 32'h0);
        check("unmapped_rd_valid", 32'(bus.read_valid), 32'h1);
        access(1, 0, 9, 8'hEE, 8'h00);
        check("unmapped_wr_err", 32'(bus.addr_err), 32'h1);
        access(0, 0, 0, 8'h00, 8'h00);
        check("unmapped_err_pulse", 32'(bus.addr_err), 32'h0);
        check("unmapped_no_change", reg_out, 32'h003C_2200);

        for (int i = 0; i < 8; i++) begin
            access(0, 1, i, 8'h00, 8'h00);
            check("b2b_valid", 32'(bus.read_valid), 32'h1);
        end
        check("b2b_last_id", 32'(bus.read_data), 32'hA5);

        for (int n = 0; n < 3000; n++) begin
            status_in = 8'($urandom);
            if ($urandom_range(0, 399) == 0) begin
                #2 reset = 1'b1;
                @(posedge clk);
                #1 reset = 1'b0;
            end else begin
                access(bit'($urandom_range(0, 2) == 0), bit'($urandom_range(0, 1)),
                       int'($urandom_range(0, 15)), 8'($urandom),
                       ($urandom_range(0, 5) == 0) ? 8'($urandom) : 8'h00);
            end
        end

        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
